// File: rtl/fm_receiver_demod_if.sv
// ---------------------------------------------------------------------------
// fm_receiver_demod_if
//   Sample/audio bus of the FM receive demodulator.
//
//   Handshake: strobe-only, no back-pressure. stb_in marks a valid I/Q pair
//   on data_in_i/data_in_q for exactly the cycle it is high and may be high
//   every cycle. stb_out is a one-cycle pulse marking data_out valid; sat
//   pulses together with stb_out when that output was clipped. data_out holds
//   its value between strobes. There is no ready signal in either direction:
//   the demodulator accepts one sample per clock unconditionally.
//
//   Signals:
//     data_in_i  WIDTH  signed in-phase sample           (master -> slave)
//     data_in_q  WIDTH  signed quadrature sample         (master -> slave)
//     stb_in     1      input sample valid               (master -> slave)
//     data_out   WIDTH  signed demodulated audio         (slave -> master)
//     stb_out    1      audio valid pulse                (slave -> master)
//     sat        1      audio clipped pulse              (slave -> master)
//     dbg_state  1      FSM state, 0 = PRIME, 1 = RUN    (slave -> master)
// ---------------------------------------------------------------------------
interface fm_receiver_demod_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0] data_in_i;
    logic signed [WIDTH-1:0] data_in_q;
    logic                    stb_in;
    logic signed [WIDTH-1:0] data_out;
    logic                    stb_out;
    logic                    sat;
    logic                    dbg_state;

    modport master (
        output data_in_i,
        output data_in_q,
        output stb_in,
        input  data_out,
        input  stb_out,
        input  sat,
        input  dbg_state
    );

    modport slave (
        input  data_in_i,
        input  data_in_q,
        input  stb_in,
        output data_out,
        output stb_out,
        output sat,
        output dbg_state
    );
endinterface

// File: rtl/fm_receiver_demod.sv
// ---------------------------------------------------------------------------
// fm_receiver_demod
//   FM demodulator for complex baseband samples. A cross-product phase
//   discriminator d[n] = I[n-1]*Q[n] - Q[n-1]*I[n] feeds an accumulate-and-dump
//   decimator (ratio RATE_DEC); each dump is shifted right by OUT_SHIFT,
//   saturated to WIDTH bits and emitted on a one-cycle strobe.
//
//   Ports:
//     clk   system clock, rising edge
//     rst   asynchronous reset, active low
//     bus   fm_receiver_demod_if.slave (samples in, audio out, debug state)
//
//   Pipeline for every accepted sample (edge numbers relative to the edge
//   that samples stb_in):
//     edge 0  S1  capture current and previous sample
//     edge 1  S2  cross products
//     edge 2  S3  discriminator difference
//     edge 3  S4  accumulate, or dump the shifted sum
//     edge 4  OUT saturate, drive data_out / stb_out / sat
//   The stages advance every clock, so latency is fixed regardless of gaps
//   between input strobes.
// ---------------------------------------------------------------------------
module fm_receiver_demod #(
    parameter int WIDTH     = 16,
    parameter int RATE_DEC  = 100,
    parameter int OUT_SHIFT = 15
) (
    input  logic                clk,
    input  logic                rst,
    fm_receiver_demod_if.slave  bus
);

    // Product, discriminator and accumulator widths. The accumulator has
    // enough headroom for RATE_DEC full-scale d-samples, so it never wraps.
    localparam int PW = 2 * WIDTH;
    localparam int DW = PW + 1;
    localparam int AW = DW + $clog2(RATE_DEC);
    localparam int CW = (RATE_DEC > 1) ? $clog2(RATE_DEC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RATE_DEC - 1);

    localparam logic signed [WIDTH-1:0] OUT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] OUT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // -----------------------------------------------------------------------
    // Control FSM: the very first sample only primes the "previous" register.
    // -----------------------------------------------------------------------
    typedef enum logic {
        PRIME = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   take_prev;
    logic   issue;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= PRIME;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        take_prev = 1'b0;
        issue     = 1'b0;
        case (state_q)
            PRIME: begin
                if (bus.stb_in) begin
                    take_prev = 1'b1;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (bus.stb_in) begin
                    take_prev = 1'b1;
                    issue     = 1'b1;
                end
            end
            default: begin
                state_d = PRIME;
            end
        endcase
    end

    assign bus.dbg_state = (state_q == RUN);

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic signed [WIDTH-1:0] prev_re_q, prev_re_d;
    logic signed [WIDTH-1:0] prev_im_q, prev_im_d;

    logic                    s1_v_q, s1_v_d;
    logic signed [WIDTH-1:0] cur_re_q, cur_re_d;
    logic signed [WIDTH-1:0] cur_im_q, cur_im_d;
    logic signed [WIDTH-1:0] old_re_q, old_re_d;
    logic signed [WIDTH-1:0] old_im_q, old_im_d;

    logic                    s2_v_q, s2_v_d;
    logic signed [PW-1:0]    p1_q, p1_d;
    logic signed [PW-1:0]    p2_q, p2_d;

    logic                    s3_v_q, s3_v_d;
    logic signed [DW-1:0]    d_q, d_d;

    logic signed [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    dump_v_q, dump_v_d;
    logic signed [AW-1:0]    y_q, y_d;

    logic signed [WIDTH-1:0] data_out_q, data_out_d;
    logic                    stb_out_q, stb_out_d;
    logic                    sat_q, sat_d;

    // Operands widened before multiplying so the product is formed at full
    // 2*WIDTH precision (sign-extending size casts).
    logic signed [PW-1:0]    old_re_x, old_im_x, cur_re_x, cur_im_x;
    logic signed [AW-1:0]    sum;
    logic [AW-WIDTH:0]       y_hi;
    logic                    y_in_range;

    always_comb begin
        old_re_x = PW'(old_re_q);
        old_im_x = PW'(old_im_q);
        cur_re_x = PW'(cur_re_q);
        cur_im_x = PW'(cur_im_q);
        sum      = acc_q + AW'(d_q);
        // y fits in WIDTH bits only when every bit from the WIDTH-1 sign
        // position upwards agrees.
        y_hi       = y_q[AW-1:WIDTH-1];
        y_in_range = (&y_hi) | ~(|y_hi);
    end

    always_comb begin
        // Previous-sample register: updated by every accepted strobe.
        prev_re_d = take_prev ? bus.data_in_i : prev_re_q;
        prev_im_d = take_prev ? bus.data_in_q : prev_im_q;

        // S1: pair the incoming sample with the one before it.
        s1_v_d   = issue;
        cur_re_d = issue ? bus.data_in_i : cur_re_q;
        cur_im_d = issue ? bus.data_in_q : cur_im_q;
        old_re_d = issue ? prev_re_q     : old_re_q;
        old_im_d = issue ? prev_im_q     : old_im_q;

        // S2: cross products.
        s2_v_d = s1_v_q;
        p1_d   = s1_v_q ? old_re_x * cur_im_x : p1_q;
        p2_d   = s1_v_q ? old_im_x * cur_re_x : p2_q;

        // S3: discriminator output, one extra bit so the difference is exact.
        s3_v_d = s2_v_q;
        d_d    = s2_v_q ? (DW'(p1_q) - DW'(p2_q)) : d_q;

        // S4: accumulate, dumping on the RATE_DEC-th sample of the frame.
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        dump_v_d = 1'b0;
        y_d      = y_q;
        if (s3_v_q) begin
            if (cnt_q == CNT_LAST) begin
                y_d      = sum >>> OUT_SHIFT;
                dump_v_d = 1'b1;
                acc_d    = '0;
                cnt_d    = '0;
            end else begin
                acc_d = sum;
                cnt_d = cnt_q + CW'(1);
            end
        end

        // OUT: saturate the dumped value; data_out holds between dumps.
        stb_out_d  = dump_v_q;
        sat_d      = dump_v_q & ~y_in_range;
        data_out_d = data_out_q;
        if (dump_v_q) begin
            if (y_in_range) begin
                data_out_d = y_q[WIDTH-1:0];
            end else begin
                data_out_d = y_q[AW-1] ? OUT_MIN : OUT_MAX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_re_q  <= '0;
            prev_im_q  <= '0;
            s1_v_q     <= 1'b0;
            cur_re_q   <= '0;
            cur_im_q   <= '0;
            old_re_q   <= '0;
            old_im_q   <= '0;
            s2_v_q     <= 1'b0;
            p1_q       <= '0;
            p2_q       <= '0;
            s3_v_q     <= 1'b0;
            d_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            dump_v_q   <= 1'b0;
            y_q        <= '0;
            data_out_q <= '0;
            stb_out_q  <= 1'b0;
            sat_q      <= 1'b0;
        end else begin
            prev_re_q  <= prev_re_d;
            prev_im_q  <= prev_im_d;
            s1_v_q     <= s1_v_d;
            cur_re_q   <= cur_re_d;
            cur_im_q   <= cur_im_d;
            old_re_q   <= old_re_d;
            old_im_q   <= old_im_d;
            s2_v_q     <= s2_v_d;
            p1_q       <= p1_d;
            p2_q       <= p2_d;
            s3_v_q     <= s3_v_d;
            d_q        <= d_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            dump_v_q   <= dump_v_d;
            y_q        <= y_d;
            data_out_q <= data_out_d;
            stb_out_q  <= stb_out_d;
            sat_q      <= sat_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.stb_out  = stb_out_q;
    assign bus.sat      = sat_q;

endmodule

// File: tb/tb_fm_receiver_demod.sv
// ---------------------------------------------------------------------------
// tb_fm_receiver_demod
//   Bench for fm_receiver_demod. dut_a uses the default decimator
//   (RATE_DEC=100, OUT_SHIFT=15); dut_b uses RATE_DEC=1, OUT_SHIFT=5.
//   A reference model works directly on the strobed I/Q stream: it forms each
//   discriminator sample with integer arithmetic, sums groups of RATE_DEC,
//   shifts and clamps, and queues the expected output together with the cycle
//   on which its last sample was accepted.
// ---------------------------------------------------------------------------
module tb_fm_receiver_demod;
    localparam int W = 16;
    localparam int LAT = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fm_receiver_demod_if #(.WIDTH(W)) bus_a ();
    fm_receiver_demod_if #(.WIDTH(W)) bus_b ();

    fm_receiver_demod #(.WIDTH(W), .RATE_DEC(100), .OUT_SHIFT(15)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a.slave)
    );

    fm_receiver_demod #(.WIDTH(W), .RATE_DEC(1), .OUT_SHIFT(5)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b.slave)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;

    // Packed entry: [48:17] accept cycle, [16] sat, [15:0] audio.
    logic [48:0] exp_q_a[$];
    logic [48:0] exp_q_b[$];
    logic [W-1:0] log_a[$];
    int out_cnt_a = 0;
    int out_cnt_b = 0;
    int sat_cnt_b = 0;

    // ---------------- reference model ----------------
    int     m_primed[2];
    longint m_pi[2];
    longint m_pq[2];
    longint m_acc[2];
    int     m_cnt[2];
    int     m_rate[2]  = '{100, 1};
    int     m_shift[2] = '{15, 5};

    function automatic void model_clear();
        for (int k = 0; k < 2; k++) begin
            m_primed[k] = 0;
            m_pi[k]     = 0;
            m_pq[k]     = 0;
            m_acc[k]    = 0;
            m_cnt[k]    = 0;
        end
    endfunction

    function automatic void model_step(input int k, input longint i, input longint q, input int acc_cyc);
        longint      d;
        longint      y;
        logic        s;
        logic [48:0] e;
        if (m_primed[k] == 0) begin
            m_primed[k] = 1;
        end else begin
            d = m_pi[k] * q - m_pq[k] * i;
            m_acc[k] = m_acc[k] + d;
            m_cnt[k] = m_cnt[k] + 1;
            if (m_cnt[k] == m_rate[k]) begin
                y = m_acc[k] >>> m_shift[k];
                s = 1'b0;
                if (y > 32767) begin
                    y = 32767;
                    s = 1'b1;
                end else if (y < -32768) begin
                    y = -32768;
                    s = 1'b1;
                end
                e = {32'(acc_cyc), s, 16'(y)};
                if (k == 0) exp_q_a.push_back(e);
                else        exp_q_b.push_back(e);
                m_acc[k] = 0;
                m_cnt[k] = 0;
            end
        end
        m_pi[k] = i;
        m_pq[k] = q;
    endfunction

    // ---------------- monitors ----------------
    logic prev_stb_a = 1'b0;

    always @(negedge clk) begin
        logic [48:0] e;
        int          lat;
        if (bus_a.sat && !bus_a.stb_out) begin
            total++; bad++;
            $display("FAIL a_sat_without_stb got sat=1 stb_out=0 required sat=0");
        end
        if (bus_a.stb_out) begin
            out_cnt_a++;
            log_a.push_back(bus_a.data_out);
            total++;
            if (prev_stb_a) begin
                bad++;
                $display("FAIL a_stb_width got stb_out high 2 cycles required 1");
            end
            if (exp_q_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_out got=%0d required none", $signed(bus_a.data_out));
            end else begin
                e = exp_q_a.pop_front();
                lat = cyc - int'(e[48:17]);
                total += 3;
                if (bus_a.data_out !== e[15:0]) begin
                    bad++;
                    $display("FAIL a_data got=%0d required=%0d", $signed(bus_a.data_out), $signed(e[15:0]));
                end
                if (bus_a.sat !== e[16]) begin
                    bad++;
                    $display("FAIL a_sat got=%0b required=%0b", bus_a.sat, e[16]);
                end
                if (lat != LAT) begin
                    bad++;
                    $display("FAIL a_latency got=%0d required=%0d", lat, LAT);
                end
            end
        end
        prev_stb_a = bus_a.stb_out;
    end

    always @(negedge clk) begin
        logic [48:0] e;
        int          lat;
        if (bus_b.sat && !bus_b.stb_out) begin
            total++; bad++;
            $display("FAIL b_sat_without_stb got sat=1 stb_out=0 required sat=0");
        end
        if (bus_b.stb_out) begin
            out_cnt_b++;
            if (bus_b.sat) sat_cnt_b++;
            if (exp_q_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_out got=%0d required none", $signed(bus_b.data_out));
            end else begin
                e = exp_q_b.pop_front();
                lat = cyc - int'(e[48:17]);
                total += 3;
                if (bus_b.data_out !== e[15:0]) begin
                    bad++;
                    $display("FAIL b_data got=%0d required=%0d", $signed(bus_b.data_out), $signed(e[15:0]));
                end
                if (bus_b.sat !== e[16]) begin
                    bad++;
                    $display("FAIL b_sat got=%0b required=%0b", bus_b.sat, e[16]);
                end
                if (lat != LAT) begin
                    bad++;
                    $display("FAIL b_latency got=%0d required=%0d", lat, LAT);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic drive(input int k, input int i, input int q, input int gap);
        if (k == 0) begin
            bus_a.data_in_i = 16'(i);
            bus_a.data_in_q = 16'(q);
            bus_a.stb_in    = 1'b1;
        end else begin
            bus_b.data_in_i = 16'(i);
            bus_b.data_in_q = 16'(q);
            bus_b.stb_in    = 1'b1;
        end
        model_step(k, i, q, cyc + 1);
        @(posedge clk); #1;
        bus_a.stb_in = 1'b0;
        bus_b.stb_in = 1'b0;
        repeat (gap) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic drain(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        bus_a.stb_in = 1'b0;
        bus_b.stb_in = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        drain(1);
    endtask

    // Phasor of amplitude amp advanced by dir*90 degrees per sample.
    function automatic void phasor(input int n, input int amp, input int dir, output int i, output int q);
        int p;
        p = ((n * dir) % 4 + 4) % 4;
        case (p)
            0: begin i = amp;  q = 0;    end
            1: begin i = 0;    q = amp;  end
            2: begin i = -amp; q = 0;    end
            default: begin i = 0; q = -amp; end
        endcase
    endfunction

    task automatic check_queues_empty(input string name);
        total++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            bad++;
            $display("FAIL %s_pending got=%0d/%0d required=0/0", name, exp_q_a.size(), exp_q_b.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus_a.data_in_i = '0; bus_a.data_in_q = '0; bus_a.stb_in = 1'b0;
        bus_b.data_in_i = '0; bus_b.data_in_q = '0; bus_b.stb_in = 1'b0;
        rst = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        total += 8;
        if (bus_a.data_out !== 16'sd0) begin bad++; $display("FAIL reset_a_data got=%0d required=0", $signed(bus_a.data_out)); end
        if (bus_a.stb_out !== 1'b0)    begin bad++; $display("FAIL reset_a_stb got=%0b required=0", bus_a.stb_out); end
        if (bus_a.sat !== 1'b0)        begin bad++; $display("FAIL reset_a_sat got=%0b required=0", bus_a.sat); end
        if (bus_a.dbg_state !== 1'b0)  begin bad++; $display("FAIL reset_a_state got=%0b required=0", bus_a.dbg_state); end
        if (bus_b.data_out !== 16'sd0) begin bad++; $display("FAIL reset_b_data got=%0d required=0", $signed(bus_b.data_out)); end
        if (bus_b.stb_out !== 1'b0)    begin bad++; $display("FAIL reset_b_stb got=%0b required=0", bus_b.stb_out); end
        if (bus_b.sat !== 1'b0)        begin bad++; $display("FAIL reset_b_sat got=%0b required=0", bus_b.sat); end
        if (bus_b.dbg_state !== 1'b0)  begin bad++; $display("FAIL reset_b_state got=%0b required=0", bus_b.dbg_state); end
        rst = 1'b1;
        drain(1);
    endtask

    task automatic test_constant();
        int c0;
        do_reset();
        c0 = out_cnt_a;
        drive(0, 16384, 0, 0);
        total++;
        if (bus_a.dbg_state !== 1'b1) begin
            bad++; $display("FAIL const_state_after_prime got=%0b required=1", bus_a.dbg_state);
        end
        for (int n = 1; n < 301; n++) drive(0, 16384, 0, 0);
        drain(10);
        total += 2;
        if (out_cnt_a - c0 != 3) begin
            bad++; $display("FAIL const_count got=%0d required=3", out_cnt_a - c0);
        end
        if (bus_a.data_out !== 16'sd0) begin
            bad++; $display("FAIL const_data got=%0d required=0", $signed(bus_a.data_out));
        end
        check_queues_empty("const");
    endtask

    task automatic test_rotation(input int amp, input int dir, input int exp_val, input logic exp_sat);
        int i, q, c0;
        do_reset();
        c0 = out_cnt_a;
        for (int n = 0; n < 201; n++) begin
            phasor(n, amp, dir, i, q);
            drive(0, i, q, 0);
        end
        drain(10);
        total += 2;
        if (out_cnt_a - c0 != 2) begin
            bad++; $display("FAIL rot_count amp=%0d dir=%0d got=%0d required=2", amp, dir, out_cnt_a - c0);
        end
        if ($signed(bus_a.data_out) != exp_val) begin
            bad++; $display("FAIL rot_data amp=%0d dir=%0d got=%0d required=%0d", amp, dir, $signed(bus_a.data_out), exp_val);
        end
        check_queues_empty("rot");
    endtask

    task automatic test_reset_mid_frame();
        int i, q, c0;
        do_reset();
        for (int n = 0; n < 151; n++) begin
            phasor(n, 1024, 1, i, q);
            drive(0, i, q, 0);
        end
        drain(8);
        check_queues_empty("midrst_pre");
        rst = 1'b0;
        #1;
        total += 4;
        if (bus_a.data_out !== 16'sd0) begin bad++; $display("FAIL midrst_data got=%0d required=0", $signed(bus_a.data_out)); end
        if (bus_a.stb_out !== 1'b0)    begin bad++; $display("FAIL midrst_stb got=%0b required=0", bus_a.stb_out); end
        if (bus_a.sat !== 1'b0)        begin bad++; $display("FAIL midrst_sat got=%0b required=0", bus_a.sat); end
        if (bus_a.dbg_state !== 1'b0)  begin bad++; $display("FAIL midrst_state got=%0b required=0", bus_a.dbg_state); end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        drain(1);
        c0 = out_cnt_a;
        for (int n = 0; n < 100; n++) begin
            phasor(n, 1024, 1, i, q);
            drive(0, i, q, 0);
        end
        drain(10);
        total++;
        if (out_cnt_a != c0) begin
            bad++; $display("FAIL midrst_early_out got=%0d required=0", out_cnt_a - c0);
        end
        phasor(100, 1024, 1, i, q);
        drive(0, i, q, 0);
        drain(10);
        total += 2;
        if (out_cnt_a - c0 != 1) begin
            bad++; $display("FAIL midrst_count got=%0d required=1", out_cnt_a - c0);
        end
        if ($signed(bus_a.data_out) != 3200) begin
            bad++; $display("FAIL midrst_value got=%0d required=3200", $signed(bus_a.data_out));
        end
        check_queues_empty("midrst");
    endtask

    task automatic test_gaps();
        int si[201];
        int sq[201];
        logic [W-1:0] seq1[$];
        for (int n = 0; n < 201; n++) begin
            si[n] = $urandom_range(65535) - 32768;
            sq[n] = $urandom_range(65535) - 32768;
        end
        do_reset();
        log_a.delete();
        for (int n = 0; n < 201; n++) drive(0, si[n], sq[n], 0);
        drain(10);
        seq1 = log_a;
        do_reset();
        log_a.delete();
        for (int n = 0; n < 201; n++) drive(0, si[n], sq[n], 3);
        drain(10);
        total++;
        if (log_a.size() != 2 || seq1.size() != 2) begin
            bad++; $display("FAIL gaps_count got=%0d/%0d required=2/2", seq1.size(), log_a.size());
        end else begin
            for (int n = 0; n < 2; n++) begin
                total++;
                if (log_a[n] !== seq1[n]) begin
                    bad++; $display("FAIL gaps_seq idx=%0d got=%0d required=%0d", n, $signed(log_a[n]), $signed(seq1[n]));
                end
            end
        end
        check_queues_empty("gaps");
    endtask

    task automatic test_back_to_back();
        int c0, i, q;
        do_reset();
        c0 = out_cnt_a;
        for (int n = 0; n < 350; n++) begin
            if ($urandom_range(9) == 0) begin
                i = ($urandom_range(1) == 1) ? 32767 : -32768;
                q = ($urandom_range(1) == 1) ? 32767 : -32768;
            end else begin
                i = $urandom_range(65535) - 32768;
                q = $urandom_range(65535) - 32768;
            end
            drive(0, i, q, ($urandom_range(3) == 0) ? $urandom_range(2) : 0);
        end
        drain(10);
        total++;
        if (out_cnt_a - c0 != 3) begin
            bad++; $display("FAIL b2b_count got=%0d required=3", out_cnt_a - c0);
        end
        check_queues_empty("b2b");
    endtask

    task automatic test_rate1();
        int i, q;
        do_reset();
        out_cnt_b = 0;
        sat_cnt_b = 0;
        for (int n = 0; n < 20; n++) begin
            phasor(n, 1024, 1, i, q);
            drive(1, i, q, 0);
        end
        drain(10);
        total += 3;
        if (out_cnt_b != 19) begin
            bad++; $display("FAIL rate1_count got=%0d required=19", out_cnt_b);
        end
        if (sat_cnt_b != 19) begin
            bad++; $display("FAIL rate1_sat_count got=%0d required=19", sat_cnt_b);
        end
        if ($signed(bus_b.data_out) != 32767) begin
            bad++; $display("FAIL rate1_data got=%0d required=32767", $signed(bus_b.data_out));
        end
        check_queues_empty("rate1");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_constant();
        test_rotation(1024, 1, 3200, 1'b0);
        test_rotation(1024, -1, -3200, 1'b0);
        test_rotation(16384, 1, 32767, 1'b1);
        test_rotation(16384, -1, -32768, 1'b1);
        test_reset_mid_frame();
        test_gaps();
        test_back_to_back();
        test_rate1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
